credit_flit_receiver: RTL and testbench

//   Router-side local input port facing a processing element.
//   - Accepts 20-bit flits from the PE's output buffer into an 8-entry FIFO.
//   - Presents flits first-word-fall-through to the router crossbar with a valid/ready handshake.
//   - Returns one credit pulse to the PE for each flit drained; this pulse drives the PE's ci input.

---
 rtl/credit_flit_receiver_if.sv | 37 +++
 rtl/credit_flit_receiver.sv | 106 ++++++++++
 tb/tb_credit_flit_receiver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/credit_flit_receiver_if.sv
// Flit/credit bundle between the PE-facing driver and the local input port.
// slave = receiver side, master = PE + crossbar side.
interface credit_flit_receiver_if #(
  parameter int DATA_W = 20,
  parameter int PTR_W  = 3
);
  logic [DATA_W-1:0] flit_in;
  logic              flit_valid;
  logic [DATA_W-1:0] flit_out;
  logic              out_valid;
  logic              out_ready;
  logic              credit_out;
  logic [PTR_W:0]    count;
  logic              ovf_err;

  modport slave (
    input  flit_in,
    input  flit_valid,
    input  out_ready,
    output flit_out,
    output out_valid,
    output credit_out,
    output count,
    output ovf_err
  );

  modport master (
    output flit_in,
    output flit_valid,
    output out_ready,
    input  flit_out,
    input  out_valid,
    input  credit_out,
    input  count,
    input  ovf_err
  );
endinterface

// File: rtl/credit_flit_receiver.sv
// Credit-based local input port: 8-deep FWFT flit FIFO, one credit per pop.
// Define CREDIT_RX_OVF_DET_EN to build the sticky overflow detector.
module credit_flit_receiver #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic clk,
  input  logic rst,
  credit_flit_receiver_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             credit_q;
  logic             credit_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A full FIFO still takes a flit when the head leaves the same cycle.
  assign pop  = !empty && bus.out_ready;
  assign push = bus.flit_valid && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = pop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case (1'b1)
      (push && !pop): count_d = count_q + (PTR_W+1)'(1);
      (pop && !push): count_d = count_q - (PTR_W+1)'(1);
      default:        count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Storage needs no reset; empty masks it on the output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.flit_in;
    end
  end

  assign bus.flit_out   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_valid  = !empty;
  assign bus.credit_out = credit_q;
  assign bus.count      = count_q;

`ifdef CREDIT_RX_OVF_DET_EN
  logic ovf_q;
  logic ovf_d;
  logic ovf_evt;

  assign ovf_evt = bus.flit_valid && full && !pop;

  always_comb begin
    ovf_d = ovf_q | ovf_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_err = ovf_q;
`else
  assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_flit_receiver.sv
// Directed bench for credit_flit_receiver.
// Inputs change and outputs are sampled on the falling edge.
module tb_credit_flit_receiver;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  credit_flit_receiver_if #(.DATA_W(20), .PTR_W(3)) bus ();

  credit_flit_receiver #(
    .DATA_W(20),
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input logic v, input logic [19:0] d,
                     input logic r);
    bus.flit_valid = v;
    bus.flit_in    = d;
    bus.out_ready  = r;
    @(negedge clk);
  endtask

  logic [19:0] exp_q [8];
  logic        ovf_exp;

  initial begin
    total  = 0;
    passed = 0;
`ifdef CREDIT_RX_OVF_DET_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    rst = 1'b0;
    bus.flit_valid = 1'b0;
    bus.flit_in    = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_credit", 32'(bus.credit_out), 0);
    chk("rst_flit", 32'(bus.flit_out), 0);
    chk("rst_ovf", 32'(bus.ovf_err), 0);
    rst = 1'b1;

    // single flit round trip
    cyc(1'b1, 20'h0ABCD, 1'b1);
    chk("t1_flit", 32'(bus.flit_out), 32'h0ABCD);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_cnt1", 32'(bus.count), 1);
    chk("t1_nocr", 32'(bus.credit_out), 0);
    cyc(1'b0, 20'h0, 1'b1);
    chk("t1_credit", 32'(bus.credit_out), 1);
    chk("t1_cnt0", 32'(bus.count), 0);
    chk("t1_empty_flit", 32'(bus.flit_out), 0);
    cyc(1'b0, 20'h0, 1'b1);
    chk("t1_credit_end", 32'(bus.credit_out), 0);

    // fill without draining
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 20'(i), 1'b0);
      chk("t2_nocredit", 32'(bus.credit_out), 0);
    end
    chk("t2_full", 32'(bus.count), 8);
    chk("t2_ovf0", 32'(bus.ovf_err), 0);

    // overflow is discarded
    cyc(1'b1, 20'h0FFFF, 1'b0);
    chk("t3_count", 32'(bus.count), 8);
    chk("t3_head", 32'(bus.flit_out), 1);
    chk("t3_nocredit", 32'(bus.credit_out), 0);
    chk("t3_ovf", 32'(bus.ovf_err), 32'(ovf_exp));
    cyc(1'b0, 20'h0, 1'b0);
    chk("t3_ovf_sticky", 32'(bus.ovf_err), 32'(ovf_exp));

    // push and pop while full
    cyc(1'b1, 20'h12345, 1'b1);
    chk("t4_count", 32'(bus.count), 8);
    chk("t4_credit", 32'(bus.credit_out), 1);
    for (int i = 0; i < 7; i++) exp_q[i] = 20'(i + 2);
    exp_q[7] = 20'h12345;
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", 32'(bus.flit_out), 32'(exp_q[i]));
      cyc(1'b0, 20'h0, 1'b1);
      chk("t4_drain_cr", 32'(bus.credit_out), 1);
    end
    chk("t4_empty", 32'(bus.out_valid), 0);
    chk("t4_cnt0", 32'(bus.count), 0);
    cyc(1'b0, 20'h0, 1'b0);
    chk("t4_cr_end", 32'(bus.credit_out), 0);
    chk("t4_ovf_hold", 32'(bus.ovf_err), 32'(ovf_exp));

    // streaming across pointer wrap
    cyc(1'b1, 20'h00100, 1'b1);
    chk("t5_first_cnt", 32'(bus.count), 1);
    chk("t5_first_cr", 32'(bus.credit_out), 0);
    for (int i = 1; i < 20; i++) begin
      chk("t5_data", 32'(bus.flit_out), 32'h100 + 32'(i) - 1);
      cyc(1'b1, 20'h00100 + 20'(i), 1'b1);
      chk("t5_cnt", 32'(bus.count), 1);
      chk("t5_cr", 32'(bus.credit_out), 1);
    end
    chk("t5_last", 32'(bus.flit_out), 32'h113);
    cyc(1'b0, 20'h0, 1'b1);
    chk("t5_end_cnt", 32'(bus.count), 0);
    chk("t5_end_cr", 32'(bus.credit_out), 1);
    cyc(1'b0, 20'h0, 1'b0);

    // async reset with data and a pending credit
    for (int i = 0; i < 6; i++) cyc(1'b1, 20'h00200 + 20'(i), 1'b0);
    cyc(1'b0, 20'h0, 1'b1);
    chk("t6_pre_cnt", 32'(bus.count), 5);
    chk("t6_pre_cr", 32'(bus.credit_out), 1);
    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("t6_cnt", 32'(bus.count), 0);
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_cr", 32'(bus.credit_out), 0);
    chk("t6_flit", 32'(bus.flit_out), 0);
    chk("t6_ovf", 32'(bus.ovf_err), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 20'h0BEEF, 1'b1);
    chk("t6_new_flit", 32'(bus.flit_out), 32'h0BEEF);
    chk("t6_new_cnt", 32'(bus.count), 1);
    cyc(1'b0, 20'h0, 1'b1);
    chk("t6_new_cr", 32'(bus.credit_out), 1);
    chk("t6_new_empty", 32'(bus.count), 0);

    // an all-zero flit is still a flit
    cyc(1'b1, 20'h0, 1'b0);
    chk("zero_valid", 32'(bus.out_valid), 1);
    chk("zero_cnt", 32'(bus.count), 1);
    cyc(1'b0, 20'h0, 1'b0);
    chk("zero_stall", 32'(bus.out_valid), 1);
    cyc(1'b0, 20'h0, 1'b1);
    chk("zero_cr", 32'(bus.credit_out), 1);
    chk("zero_cnt0", 32'(bus.count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
